// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one multicycle arithmetic unit between NREQ requesters using
//   round-robin arbitration. The winner's op/a/b are captured on the grant
//   edge and held stable for the whole operation, because the unit samples
//   its operands late. The arbiter pulses start, waits for done (or a
//   timeout), then returns the result to the winning requester.
//
// Handshake semantics (all one-hot vectors, one bit per requester):
//   req[i] is a level. The requester holds req[i] and its operands until it
//   sees grant[i] (a 1-cycle pulse on the edge the operands are captured).
//   rsp_valid[i] is a 1-cycle pulse carrying rsp_data/rsp_err. A req[i] still
//   high after its response is a new request. The unit side is a start pulse
//   followed some cycles later by a done pulse with alu_result valid.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req, req_op/a/b       per-requester request level and packed operands
//   grant                 one-hot accept pulse
//   rsp_valid/data/err    one-hot response pulse, held result, timeout flag
//   busy                  high whenever the FSM is not idle
//   alu_start/op/a/b      to the shared unit
//   alu_done/result       from the shared unit
//   state_dbg             current FSM state for observation

module alu_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [15:0]         rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic                alu_start,
  output logic [1:0]          alu_op,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  input  logic                alu_done,
  input  logic [15:0]         alu_result,
  output logic [1:0]          state_dbg
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   win_sel;
  logic [IW-1:0]   scan_idx;
  logic            found;
  logic [7:0]      cnt;
  logic [7:0]      cnt_inc;
  logic            timeout_hit;
  logic [1:0]      sel_op;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;
  logic [NREQ-1:0] one;

  assign one         = {{(NREQ-1){1'b0}}, 1'b1};
  assign cnt_inc     = cnt + 8'd1;
  assign timeout_hit = (cnt_inc == 8'(TIMEOUT));
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  // Round-robin scan: first set request at or after rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    win_sel  = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IW'((32'(rr_ptr) + 32'(k)) % NREQ);
      if (!found && req[scan_idx]) begin
        found   = 1'b1;
        win_sel = scan_idx;
      end
    end
  end

  // Operand mux for the selected requester (constant part-selects only).
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_sel == IW'(j)) begin
        sel_op = req_op[2*j +: 2];
        sel_a  = req_a[8*j +: 8];
        sel_b  = req_b[8*j +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_done || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered pulse outputs. grant, rsp_valid and alu_start
  // default low every edge so each is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      win       <= '0;
      cnt       <= '0;
      grant     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_start <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      grant     <= '0;
      rsp_valid <= '0;
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant     <= one << win_sel;
            win       <= win_sel;
            alu_op    <= sel_op;
            alu_a     <= sel_a;
            alu_b     <= sel_b;
            alu_start <= 1'b1;
          end
        end
        ISSUE: begin
          cnt <= '0;
        end
        WAIT: begin
          // done has priority over a timeout landing on the same edge
          if (alu_done) begin
            rsp_data <= alu_result;
            rsp_err  <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (timeout_hit) begin
              rsp_data <= 16'hDEAD;
              rsp_err  <= 1'b1;
            end
          end
        end
        RESP: begin
          rsp_valid <= one << win;
          if (32'(win) == NREQ - 1) rr_ptr <= '0;
          else                      rr_ptr <= win + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
